// File: rtl/seq_chunk_adder_if.sv
// Handshake bundle for seq_chunk_adder: operand side (in_*) and result side (out_*).
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, data_1, data_2, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, data_1, data_2, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH bits processed CHUNK bits per clock with a registered carry.
// Optional SEQ_ADDER_PIPE_ACCEPT_EN lets a new operation be accepted in the same edge as the result handshake.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per cycle, chunk index idx_q
// DONE  | result held, out_valid=1 until consumed
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic              clk,
    input logic              rst_n,
    seq_chunk_adder_if.slave bus
);
    localparam int NUM_CHUNKS = WIDTH / CHUNK;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CHUNKS - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept, step, in_ready_c, out_valid_c;
    logic [31:0]      bit_off;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic [CHUNK-1:0] a_slice, b_slice, chunk_sum;
    logic             chunk_cout, chunk_cmsb;

    assign bit_off = 32'(idx_q) * 32'(CHUNK);
    assign a_shift = op_a_q >> bit_off;
    assign b_shift = op_b_q >> bit_off;
    assign a_slice = a_shift[CHUNK-1:0];
    assign b_slice = b_shift[CHUNK-1:0];

    // Bit-level ripple inside one chunk; the carry into the top bit feeds overflow detection.
    always_comb begin
        logic c;
        chunk_sum  = '0;
        c          = carry_q;
        chunk_cmsb = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = a_slice[i] ^ b_slice[i] ^ c;
            chunk_cmsb   = c;
            c            = (a_slice[i] & b_slice[i]) | (a_slice[i] & c) | (b_slice[i] & c);
        end
        chunk_cout = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        accept      = 1'b0;
        step        = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
`ifdef SEQ_ADDER_PIPE_ACCEPT_EN
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Sum is not cleared on accept: the previous result is overwritten slice by slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_a_q  <= bus.data_1;
            op_b_q  <= bus.sub ? ~bus.data_2 : bus.data_2;
            carry_q <= bus.carry_in;
            idx_q   <= '0;
        end else if (step) begin
            sum_q   <= (sum_q & ~(SLICE_MASK << bit_off)) | (WIDTH'(chunk_sum) << bit_off);
            carry_q <= chunk_cout;
            if (idx_q == LAST_IDX) begin
                cout_q <= chunk_cout;
                ovf_q  <= chunk_cmsb ^ chunk_cout;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;
endmodule
